// File: rtl/vga_frame_monitor_if.sv
// VGA output bus of the mandelbrot generator, as seen by the frame monitor.
// The master drives the bus and the monitor takes the slave view.
interface vga_frame_monitor_if #(
    parameter int COLOR_W = 10
) ();
    logic               pix_en;
    logic               vga_blank;
    logic               vga_hs;
    logic               vga_vs;
    logic [COLOR_W-1:0] vga_r;
    logic [COLOR_W-1:0] vga_g;
    logic [COLOR_W-1:0] vga_b;

    modport master (
        output pix_en, vga_blank, vga_hs, vga_vs,
        output vga_r, vga_g, vga_b
    );

    modport slave (
        input pix_en, vga_blank, vga_hs, vga_vs,
        input vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_frame_monitor.sv
// VGA frame monitor: sync/active-area geometry checks, per-frame checksum,
// frame counting and a sticky stop after a programmable number of frames.
module vga_frame_monitor #(
    parameter int COLOR_W     = 10,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int CNT_W       = 12,
    parameter bit SYNC_POL    = 1'b0,
    parameter int STOP_FRAMES = 1
) (
    input  logic               clk,
    input  logic               rst,
    vga_frame_monitor_if.slave vga,
    output logic               frame_done,
    output logic [15:0]        frame_count,
    output logic [CNT_W-1:0]   last_lines,
    output logic [31:0]        checksum,
    output logic               err_hact,
    output logic               err_vact,
    output logic               err_sync,
    output logic               stop
);

    typedef enum logic {IDLE, FRAME} state_e;

    state_e                 state_q, state_d;
    logic                   hs_prev_q, hs_prev_d;
    logic                   vs_prev_q, vs_prev_d;
    logic [CNT_W-1:0]       pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]       line_cnt_q, line_cnt_d;
    logic [31:0]            acc_q, acc_d;
    logic                   frame_done_q, frame_done_d;
    logic [15:0]            frame_count_q, frame_count_d;
    logic [CNT_W-1:0]       last_lines_q, last_lines_d;
    logic [31:0]            checksum_q, checksum_d;
    logic                   err_hact_q, err_hact_d;
    logic                   err_vact_q, err_vact_d;
    logic                   err_sync_q, err_sync_d;
    logic                   stop_q, stop_d;

    logic                   hs_act, vs_act;
    logic                   hs_lead, vs_lead;
    logic [3*COLOR_W-1:0]   pix;

    // History registers hold "sync was active", so reset to 0 means inactive.
    assign hs_act  = (vga.vga_hs == SYNC_POL);
    assign vs_act  = (vga.vga_vs == SYNC_POL);
    assign hs_lead = hs_act && !hs_prev_q;
    assign vs_lead = vs_act && !vs_prev_q;
    assign pix     = {vga.vga_r, vga.vga_g, vga.vga_b};

    always_comb begin
        state_d       = state_q;
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        acc_d         = acc_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        last_lines_d  = last_lines_q;
        checksum_d    = checksum_q;
        err_hact_d    = err_hact_q;
        err_vact_d    = err_vact_q;
        err_sync_d    = err_sync_q;
        stop_d        = stop_q;
        if (vga.pix_en) begin
            hs_prev_d = hs_act;
            vs_prev_d = vs_act;
            unique case (state_q)
                IDLE: begin
                    if (vs_lead) state_d = FRAME;
                end
                FRAME: begin
                    if (vga.vga_blank && !hs_act && !vs_act) begin
                        if (!(&pix_cnt_q)) pix_cnt_d = pix_cnt_q + 1'b1;
                        acc_d = {acc_q[30:0], acc_q[31]} + 32'(pix);
                    end
                    if (vga.vga_blank && (hs_act || vs_act)) err_sync_d = 1'b1;
                    if (hs_lead) begin
                        if (pix_cnt_q != '0) begin
                            if (!(&line_cnt_q)) line_cnt_d = line_cnt_q + 1'b1;
                            if (pix_cnt_q != CNT_W'(H_ACTIVE)) err_hact_d = 1'b1;
                        end
                        pix_cnt_d = '0;
                    end
                    // Frame close sees the line count already updated by a coincident HS edge.
                    if (vs_lead) begin
                        if (line_cnt_d != CNT_W'(V_ACTIVE)) err_vact_d = 1'b1;
                        last_lines_d  = line_cnt_d;
                        checksum_d    = acc_q;
                        acc_d         = '0;
                        line_cnt_d    = '0;
                        pix_cnt_d     = '0;
                        frame_count_d = frame_count_q + 16'd1;
                        frame_done_d  = 1'b1;
                        if (STOP_FRAMES != 0 && frame_count_d == 16'(STOP_FRAMES))
                            stop_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            acc_q         <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            last_lines_q  <= '0;
            checksum_q    <= '0;
            err_hact_q    <= 1'b0;
            err_vact_q    <= 1'b0;
            err_sync_q    <= 1'b0;
            stop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            acc_q         <= acc_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            last_lines_q  <= last_lines_d;
            checksum_q    <= checksum_d;
            err_hact_q    <= err_hact_d;
            err_vact_q    <= err_vact_d;
            err_sync_q    <= err_sync_d;
            stop_q        <= stop_d;
        end
    end

    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign last_lines  = last_lines_q;
    assign checksum    = checksum_q;
    assign err_hact    = err_hact_q;
    assign err_vact    = err_vact_q;
    assign err_sync    = err_sync_q;
    assign stop        = stop_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor: table of frame scenarios with a frame_done
// scoreboard, plus hand sequences for start-up and mid-frame reset.
module tb_vga_frame_monitor;

    localparam int CW = 4;
    localparam int NW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_frame_monitor_if #(.COLOR_W(CW)) vif ();

    logic          frame_done;
    logic [15:0]   frame_count;
    logic [NW-1:0] last_lines;
    logic [31:0]   checksum;
    logic          err_hact, err_vact, err_sync, stop;

    vga_frame_monitor #(
        .COLOR_W(CW), .H_ACTIVE(8), .V_ACTIVE(4), .CNT_W(NW),
        .SYNC_POL(1'b0), .STOP_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .vga(vif),
        .frame_done(frame_done), .frame_count(frame_count),
        .last_lines(last_lines), .checksum(checksum),
        .err_hact(err_hact), .err_vact(err_vact),
        .err_sync(err_sync), .stop(stop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nlines;
        int short_idx;
        int short_len;
        bit simul;
        bit sync_bad;
        bit noise;
        bit ones;
        int exp_lines;
        bit exp_hact;
        bit exp_vact;
        bit exp_sync;
        int exp_fc;
        bit exp_stop;
    } vec_t;

    typedef struct {
        int          lines;
        logic [31:0] cks;
        int          fc;
        bit          hact;
        bit          vact;
        bit          sync;
        bit          stop;
        bit          ones;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t tbl[6];
    vec_t post;

    int n_tests = 0;
    int n_fail  = 0;
    bit m_hact, m_sync;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample(input logic blank, input logic hs, input logic vs,
                          input logic [11:0] rgb);
        @(negedge clk);
        vif.vga_blank = blank;
        vif.vga_hs    = hs;
        vif.vga_vs    = vs;
        {vif.vga_r, vif.vga_g, vif.vga_b} = rgb;
        vif.pix_en    = 1'b1;
        @(negedge clk);
        vif.pix_en    = 1'b0;
    endtask

    task automatic noise(input int fc);
        logic [15:0] r;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            r = 16'($urandom);
            vif.vga_blank = r[0];
            vif.vga_hs    = r[1];
            vif.vga_vs    = r[2];
            {vif.vga_r, vif.vga_g, vif.vga_b} = r[15:4];
        end
        @(negedge clk);
        vif.vga_blank = 1'b0;
        vif.vga_hs    = 1'b1;
        vif.vga_vs    = 1'b1;
        @(negedge clk);
        chk("gated_frame_count", frame_count, fc);
        chk("gated_err_sync", err_sync, m_sync);
        chk("gated_err_hact", err_hact, m_hact);
    endtask

    task automatic drive_frame(input vec_t v);
        logic [31:0] acc;
        logic [11:0] px;
        int          len;
        exp_t        e;
        acc = '0;
        for (int l = 0; l < v.nlines; l++) begin
            len = (l == v.short_idx) ? v.short_len : 8;
            for (int p = 0; p < len; p++) begin
                px  = v.ones ? 12'h001 : 12'($urandom);
                sample(1'b1, 1'b1, 1'b1, px);
                acc = {acc[30:0], acc[31]} + {20'd0, px};
            end
            sample(1'b0, 1'b1, 1'b1, 12'h000);
            if (v.noise && l == 0) noise(v.exp_fc - 1);
            if (!(v.simul && l == v.nlines - 1)) begin
                if (v.sync_bad && l == 1) begin
                    sample(1'b1, 1'b0, 1'b1, 12'hABC);
                    m_sync = 1'b1;
                end else begin
                    sample(1'b0, 1'b0, 1'b1, 12'h000);
                end
                if (len != 8) m_hact = 1'b1;
                chk("line_err_hact", err_hact, m_hact);
                chk("line_err_sync", err_sync, m_sync);
                sample(1'b0, 1'b1, 1'b1, 12'h000);
            end
        end
        e.lines = v.exp_lines;
        e.cks   = acc;
        e.fc    = v.exp_fc;
        e.hact  = v.exp_hact;
        e.vact  = v.exp_vact;
        e.sync  = v.exp_sync;
        e.stop  = v.exp_stop;
        e.ones  = v.ones;
        sbq.push_back(e);
        sample(1'b0, v.simul ? 1'b0 : 1'b1, 1'b0, 12'h000);
        chk("frame_done_pulse", frame_done, 1'b1);
        @(negedge clk);
        chk("frame_done_low", frame_done, 1'b0);
        sample(1'b0, 1'b1, 1'b1, 12'h000);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
        chk({tag, "_last_lines"}, last_lines, 0);
        chk({tag, "_checksum"}, checksum, 0);
        chk({tag, "_err_hact"}, err_hact, 0);
        chk({tag, "_err_vact"}, err_vact, 0);
        chk({tag, "_err_sync"}, err_sync, 0);
        chk({tag, "_stop"}, stop, 0);
    endtask

    always @(negedge clk) begin
        if (frame_done) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame_done: got 1 expected 0 at %0t", $time);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_last_lines", last_lines, mon_e.lines);
                chk("sb_checksum", checksum, mon_e.cks);
                chk("sb_frame_count", frame_count, mon_e.fc);
                chk("sb_err_hact", err_hact, mon_e.hact);
                chk("sb_err_vact", err_vact, mon_e.vact);
                chk("sb_err_sync", err_sync, mon_e.sync);
                chk("sb_stop", stop, mon_e.stop);
                if (mon_e.ones) chk("sb_checksum_ones", checksum, 32'hFFFF_FFFF);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4, -1, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        tbl[1] = '{4, -1, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 2, 1'b1};
        tbl[2] = '{4, -1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 3, 1'b1};
        tbl[3] = '{4, -1, 8, 1'b0, 1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1, 4, 1'b1};
        tbl[4] = '{4,  2, 7, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b1, 5, 1'b1};
        tbl[5] = '{3, -1, 8, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b1, 6, 1'b1};
        post   = '{4, -1, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1, 1'b0};

        vif.pix_en    = 1'b0;
        vif.vga_blank = 1'b0;
        vif.vga_hs    = 1'b1;
        vif.vga_vs    = 1'b1;
        vif.vga_r     = '0;
        vif.vga_g     = '0;
        vif.vga_b     = '0;
        m_hact = 1'b0;
        m_sync = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        sample(1'b0, 1'b1, 1'b0, 12'h000);
        chk("first_vs_no_done", frame_done, 1'b0);
        sample(1'b0, 1'b1, 1'b1, 12'h000);

        for (int i = 0; i < 6; i++) drive_frame(tbl[i]);

        for (int p = 0; p < 3; p++) sample(1'b1, 1'b1, 1'b1, 12'h5A5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("midrst");
        chk("midrst_queue_empty", sbq.size(), 0);
        m_hact = 1'b0;
        m_sync = 1'b0;

        sample(1'b0, 1'b1, 1'b0, 12'h000);
        chk("rst_first_vs_no_done", frame_done, 1'b0);
        sample(1'b0, 1'b1, 1'b1, 12'h000);
        drive_frame(post);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

Synthesizable, parametrised VGA frame monitor that replaces simulator-side pixel capture for the mandelbrot generator. It sits on the generator's VGA output bus, on a single clock with a pixel-enable strobe. Per frame it:
- checks sync and active-area geometry;
- computes a 32-bit checksum of visible pixels;
- counts frames and raises a sticky stop after a programmable number of frames, for on-board or simulation run control.

## Interface
- COLOR_W, 10, bits per colour channel; legal range 1..10.
- H_ACTIVE, 640, required visible pixels per line.
- V_ACTIVE, 480, required visible lines per frame.
- CNT_W, 12, width of the pixel and line counters.
- SYNC_POL, 0, active level of HS and VS (0 = active-low).
- STOP_FRAMES, 1, completed frames before stop asserts; 0 disables stop.

- clk  in  1  system clock.
- rst  in  1  reset, synchronous and active-high.
- pix_en  in  1  pixel strobe; all VGA inputs are sampled only when it is 1.
- vga_blank  in  1  1 = visible pixel, 0 = blanking.
- vga_hs  in  1  horizontal sync.
- vga_vs  in  1  vertical sync.
- vga_r, vga_g, vga_b  in  COLOR_W each  pixel colour.
- frame_done  out  1  one-cycle pulse when a frame closes.
- frame_count  out  16  completed frames; wraps modulo 2^16.
- last_lines  out  CNT_W  visible-line count of the last closed frame.
- checksum  out  32  checksum of the last closed frame.
- err_hact  out  1  sticky: a visible line's pixel count was not H_ACTIVE.
- err_vact  out  1  sticky: a frame's visible-line count was not V_ACTIVE.
- err_sync  out  1  sticky: vga_blank was 1 while HS or VS was active.
- stop  out  1  sticky: frame_count has reached STOP_FRAMES.

## Operation
- **Edge detection.** The previous sampled HS and VS are held in registers updated only when pix_en=1. A leading edge is a transition from inactive to active level. The history registers reset to the inactive level.
- **State machine.**
  - IDLE (reset state): ignores pixel data; moves to FRAME on the first VS leading edge. This first edge does not close a frame and does not pulse frame_done.
  - FRAME: performs measurement and returns to FRAME on every subsequent VS leading edge.
- **Pixel sample** (FRAME, pix_en=1, vga_blank=1, HS and VS both inactive):
  - pix_cnt increments, saturating at all-ones.
  - The running checksum updates: acc <= rotl(acc,1) + {r,g,b}, with {r,g,b} zero-extended to 32 bits.
- **Sync error.** A sample with vga_blank=1 while HS or VS is active sets err_sync. That sample is neither counted nor summed.
- **HS leading edge (line close).**
  - If pix_cnt != 0: increment line_cnt (saturating), and set err_hact if pix_cnt != H_ACTIVE.
  - Clear pix_cnt.
- **VS leading edge (frame close).**
  - Perform the line close first on the same sample if HS also leads.
  - Set err_vact if line_cnt != V_ACTIVE.
  - Load last_lines <= line_cnt and checksum <= acc.
  - Clear acc, line_cnt and pix_cnt.
  - Increment frame_count and pulse frame_done.
- **Stop.** stop sets when STOP_FRAMES != 0 and the incremented frame_count equals STOP_FRAMES. It stays set until rst, and monitoring continues while it is set.

## Timing
- All outputs are registered. Reset value of every output is 0.
- frame_done is high exactly on the clk cycle after the pix_en sample carrying the VS leading edge. frame_count, last_lines, checksum, err_vact and stop update on that same cycle.
- err_hact and err_sync are visible one cycle after the offending sample.
- Cycles with pix_en=0 change no state, including the edge-history registers.
- rst mid-frame aborts the measurement and returns to IDLE with all counters, the accumulator and the sticky flags cleared. rst has priority over every other event in the same cycle.
- Latency from VS leading edge to valid checksum: 1 clk.

## Test plan
Parameters for all scenarios: H_ACTIVE=8, V_ACTIVE=4, COLOR_W=4, STOP_FRAMES=2.
- **Checksum and frame close.** Reset, then two clean frames with pix_en every other clk and pixel {r,g,b}=12'h001 throughout -> the first VS edge gives no frame_done. At frame 1 close: frame_done one pulse, last_lines=4, checksum equals the rotl-add of 32 ones (golden value computed by the bench), no errors. After frame 2: frame_count=2, stop=1.
- **Short line.** One line with 7 visible pixels -> err_hact=1 one cycle after that line's HS edge. err_vact stays 0 and last_lines=4.
- **Missing line.** A frame with 3 visible lines -> at frame close err_vact=1 and last_lines=3.
- **Simultaneous edges.** HS and VS leading edges on the same sample after the 4th line's pixels -> the line is counted (last_lines=4) and err_vact=0.
- **Sync error and pix_en gating.** vga_blank=1 during HS active -> err_sync=1, checksum unaffected. Toggling inputs with pix_en=0 -> no counter change.
- **Reset mid-frame.** Assert rst mid-frame -> next cycle all outputs are 0. The following VS leading edge produces no frame_done; the one after it produces frame_done.
